load_unit: RTL and testbench

Sequential load controller for the data-memory port, the read-side counterpart of the store formatter. It accepts one load at a time from the core (address plus funct3), checks alignment, and issues a word-aligned read with a ready handshake. It then extracts the addressed byte, halfword or word from the returned word, applies sign or zero extension, and returns the result with a one-cycle valid pulse. Misaligned accesses and memory timeouts are reported as one-cycle fault pulses.

---
 rtl/load_unit.sv | 175 +++++++++++++++++
 tb/tb_load_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit
//   Sequential load controller for the data-memory read port. Accepts one
//   load at a time (address + funct3), checks alignment, issues a word-aligned
//   read and waits for iMemReady. It then extracts the addressed byte,
//   halfword or word, sign/zero-extends it and returns it with a one-cycle
//   oValid pulse. Misaligned requests and memory timeouts give one-cycle
//   fault pulses instead.
//
//   Handshakes: iLoadReq is sampled only while idle (oBusy=0); the core holds
//   it until accepted. oMemRead is held high with oMemAddr stable until a
//   cycle in which iMemReady=1; that cycle's iMemData is captured. iMemReady
//   in any other state is ignored.
//
// Ports
//   iCLK, iRST_N          clock, synchronous active-low reset
//   iLoadReq              load request from the core
//   iAddress[31:0]        byte address
//   iFunct3[2:0]          000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, else LW
//   oBusy                 high in every state except IDLE
//   oMemRead              read request, high only in REQ
//   oMemAddr[31:0]        word-aligned read address, registered at acceptance
//   iMemReady             iMemData valid this cycle
//   iMemData[31:0]        little-endian read word
//   oValid                one-cycle pulse, oData valid
//   oData[31:0]           extended load result, 0 when not valid
//   oMisaligned           one-cycle pulse, misaligned request (no access made)
//   oAccessFault          one-cycle pulse, memory timed out
//   oState[1:0]           current FSM state (debug)
// ---------------------------------------------------------------------------
module load_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iLoadReq,
    input  logic [31:0] iAddress,
    input  logic [2:0]  iFunct3,
    output logic        oBusy,
    output logic        oMemRead,
    output logic [31:0] oMemAddr,
    input  logic        iMemReady,
    input  logic [31:0] iMemData,
    output logic        oValid,
    output logic [31:0] oData,
    output logic        oMisaligned,
    output logic        oAccessFault,
    output logic [1:0]  oState
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        FAULT = 2'd3
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [CW-1:0] waitCnt;
    logic [1:0]  offsetReg;
    logic [2:0]  funct3Reg;
    logic [31:0] memAddrReg;
    logic [31:0] dataReg;
    logic        faultIsAccess;
    logic        reqMisaligned;
    logic        lastCount;

    // Byte/halfword extraction with sign or zero extension.
    function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Alignment check on the live request; only consulted in IDLE.
    always_comb begin
        reqMisaligned = 1'b0;
        case (iFunct3)
            3'b000, 3'b100: reqMisaligned = 1'b0;
            3'b001, 3'b101: reqMisaligned = iAddress[0];
            default:        reqMisaligned = |iAddress[1:0];
        endcase
    end

    assign lastCount = (waitCnt == CW'(TIMEOUT - 1));

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (iLoadReq) begin
                    nextState = reqMisaligned ? FAULT : REQ;
                end
            end
            REQ: begin
                // Ready takes priority over the timeout in the same cycle.
                if (iMemReady) begin
                    nextState = RESP;
                end else if (lastCount) begin
                    nextState = FAULT;
                end
            end
            RESP:    nextState = IDLE;
            FAULT:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state         <= IDLE;
            waitCnt       <= '0;
            offsetReg     <= 2'd0;
            funct3Reg     <= 3'd0;
            memAddrReg    <= 32'd0;
            dataReg       <= 32'd0;
            faultIsAccess <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (iLoadReq) begin
                        offsetReg     <= iAddress[1:0];
                        funct3Reg     <= iFunct3;
                        memAddrReg    <= {iAddress[31:2], 2'b00};
                        waitCnt       <= '0;
                        faultIsAccess <= 1'b0;
                    end
                end
                REQ: begin
                    if (iMemReady) begin
                        dataReg <= extendLoad(iMemData, offsetReg, funct3Reg);
                    end else if (lastCount) begin
                        faultIsAccess <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state only.
    assign oBusy        = (state != IDLE);
    assign oMemRead     = (state == REQ);
    assign oMemAddr     = memAddrReg;
    assign oValid       = (state == RESP);
    assign oData        = (state == RESP) ? dataReg : 32'd0;
    assign oMisaligned  = (state == FAULT) && !faultIsAccess;
    assign oAccessFault = (state == FAULT) && faultIsAccess;
    assign oState       = state;

endmodule

// File: tb/tb_load_unit.sv
// ---------------------------------------------------------------------------
// tb_load_unit
//   Self-checking bench for load_unit (TIMEOUT=4). A table of load vectors
//   plus randomized loads is driven through one task; the expected response
//   pulse {oValid, oMisaligned, oAccessFault, oData} is queued when a load is
//   driven and compared when the DUT pulses. The task also checks per-cycle
//   oBusy/oMemRead/oMemAddr and the exact response cycle. Hand-written
//   sequences cover held iLoadReq and reset during REQ.
// ---------------------------------------------------------------------------
module tb_load_unit;

    localparam int TIMEOUT = 4;
    localparam logic [31:0] W0 = 32'h8040FF7F;

    logic        iCLK;
    logic        iRST_N;
    logic        iLoadReq;
    logic [31:0] iAddress;
    logic [2:0]  iFunct3;
    logic        oBusy;
    logic        oMemRead;
    logic [31:0] oMemAddr;
    logic        iMemReady;
    logic [31:0] iMemData;
    logic        oValid;
    logic [31:0] oData;
    logic        oMisaligned;
    logic        oAccessFault;
    logic [1:0]  oState;

    load_unit #(.TIMEOUT(TIMEOUT)) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .iLoadReq(iLoadReq),
        .iAddress(iAddress),
        .iFunct3(iFunct3),
        .oBusy(oBusy),
        .oMemRead(oMemRead),
        .oMemAddr(oMemAddr),
        .iMemReady(iMemReady),
        .iMemData(iMemData),
        .oValid(oValid),
        .oData(oData),
        .oMisaligned(oMisaligned),
        .oAccessFault(oAccessFault),
        .oState(oState)
    );

    // ---------------- clock ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [34:0] exp_q[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Response monitor: every pulse must match the head of the queue.
    always @(negedge iCLK) begin
        if (iRST_N && (oValid || oMisaligned || oAccessFault)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual=%h required=none",
                         {oValid, oMisaligned, oAccessFault, oData});
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                if ({oValid, oMisaligned, oAccessFault, oData} !== e) begin
                    failures++;
                    $display("FAIL response actual=%h required=%h",
                             {oValid, oMisaligned, oAccessFault, oData}, e);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] modelData(input logic [31:0] a, input logic [2:0] f3,
                                              input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> (8 * a[1:0]);
        b  = sh[7:0];
        sh = w >> (16 * a[1]);
        h  = sh[15:0];
        if (f3 == 3'b000) return 32'(signed'(b));
        if (f3 == 3'b001) return 32'(signed'(h));
        if (f3 == 3'b100) return {24'd0, b};
        if (f3 == 3'b101) return {16'd0, h};
        return w;
    endfunction

    function automatic bit modelMis(input logic [31:0] a, input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    // ---------------- driver ----------------
    // delay: number of REQ cycles without ready before ready (-1 = never).
    // exp: {valid, misaligned, accessFault, data}.
    task automatic runLoad(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] word, input int delay,
                           input logic [34:0] exp, input bit hold);
        bit mis;
        bit acc;
        int expCycle;
        int reqCycles;
        mis = exp[33];
        acc = exp[32];
        expCycle  = mis ? 1 : (acc ? TIMEOUT + 1 : delay + 2);
        reqCycles = mis ? 0 : (acc ? TIMEOUT : delay + 1);
        exp_q.push_back(exp);
        @(negedge iCLK);
        iLoadReq  = 1'b1;
        iAddress  = addr;
        iFunct3   = f3;
        iMemData  = word;
        iMemReady = 1'b0;
        for (int c = 1; c <= expCycle + 1; c++) begin
            @(negedge iCLK);
            check($sformatf("busy_c%0d", c), 72'(oBusy), 72'(c <= expCycle));
            check($sformatf("memread_c%0d", c), 72'(oMemRead), 72'(c <= reqCycles));
            check($sformatf("pulse_c%0d", c), 72'(oValid | oMisaligned | oAccessFault),
                  72'(c == expCycle));
            if (c == 1 && !mis) check("memaddr", 72'(oMemAddr), 72'({addr[31:2], 2'b00}));
            if (!hold) iLoadReq = 1'b0;
            iMemReady = (!mis && !acc && (c - 1 == delay));
        end
        iMemReady = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] word;
        int          delay;
        logic [34:0] exp;
    } vecT;

    vecT vecs[16];

    initial begin
        vecs[0]  = '{32'h100, 3'b000, W0, 0,  {3'b100, 32'h0000007F}};
        vecs[1]  = '{32'h101, 3'b000, W0, 1,  {3'b100, 32'hFFFFFFFF}};
        vecs[2]  = '{32'h103, 3'b100, W0, 0,  {3'b100, 32'h00000080}};
        vecs[3]  = '{32'h102, 3'b001, W0, 0,  {3'b100, 32'hFFFF8040}};
        vecs[4]  = '{32'h100, 3'b101, W0, 2,  {3'b100, 32'h0000FF7F}};
        vecs[5]  = '{32'h100, 3'b010, W0, 0,  {3'b100, 32'h8040FF7F}};
        vecs[6]  = '{32'h100, 3'b011, W0, 0,  {3'b100, 32'h8040FF7F}};
        vecs[7]  = '{32'h102, 3'b010, W0, 0,  {3'b010, 32'h00000000}};
        vecs[8]  = '{32'h101, 3'b001, W0, 0,  {3'b010, 32'h00000000}};
        vecs[9]  = '{32'h100, 3'b010, W0, -1, {3'b001, 32'h00000000}};
        vecs[10] = '{32'h100, 3'b010, W0, 3,  {3'b100, 32'h8040FF7F}};
        vecs[11] = '{32'h102, 3'b101, W0, 1,  {3'b100, 32'h00008040}};
        vecs[12] = '{32'h106, 3'b000, W0, 0,  {3'b100, 32'h00000040}};
        vecs[13] = '{32'h10C, 3'b111, W0, 0,  {3'b100, 32'h8040FF7F}};
        vecs[14] = '{32'h101, 3'b100, W0, 0,  {3'b100, 32'h000000FF}};
        vecs[15] = '{32'h103, 3'b001, W0, 0,  {3'b010, 32'h00000000}};
    end

    // ---------------- test sequence ----------------
    initial begin
        iRST_N    = 1'b0;
        iLoadReq  = 1'b0;
        iAddress  = 32'd0;
        iFunct3   = 3'd0;
        iMemReady = 1'b0;
        iMemData  = 32'd0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_busy",    72'(oBusy), 72'(0));
        check("rst_memread", 72'(oMemRead), 72'(0));
        check("rst_memaddr", 72'(oMemAddr), 72'(0));
        check("rst_outputs", 72'({oValid, oData, oMisaligned, oAccessFault}), 72'(0));
        check("rst_state",   72'(oState), 72'(0));
        iRST_N = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            runLoad(vecs[i].addr, vecs[i].f3, vecs[i].word, vecs[i].delay, vecs[i].exp, 1'b0);
        end

        // Randomized loads against the model.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [2:0]  f;
            logic [31:0] w;
            a = $urandom;
            f = 3'($urandom_range(0, 7));
            w = $urandom;
            if (modelMis(a, f)) runLoad(a, f, w, 0, {3'b010, 32'd0}, 1'b0);
            else runLoad(a, f, w, $urandom_range(0, 2), {3'b100, modelData(a, f, w)}, 1'b0);
        end

        // Ready delayed 3 cycles with iLoadReq held high: valid at N+5, and
        // the next load is only accepted at the end of the IDLE cycle.
        runLoad(32'h100, 3'b010, W0, 3, {3'b100, 32'h8040FF7F}, 1'b1);
        exp_q.push_back({3'b100, 32'h8040FF7F});
        @(negedge iCLK);
        check("hold_second_accept", 72'({oBusy, oMemRead}), 72'(2'b11));
        iLoadReq  = 1'b0;
        iMemReady = 1'b1;
        @(negedge iCLK);
        check("hold_second_valid", 72'(oValid), 72'(1));
        iMemReady = 1'b0;
        @(negedge iCLK);
        check("hold_second_idle", 72'(oBusy), 72'(0));

        // Reset during REQ abandons the read.
        iLoadReq = 1'b1;
        iAddress = 32'h100;
        iFunct3  = 3'b010;
        iMemData = W0;
        @(negedge iCLK);
        iLoadReq = 1'b0;
        check("rstmid_in_req", 72'(oMemRead), 72'(1));
        iRST_N = 1'b0;
        @(negedge iCLK);
        check("rstmid_busy_read", 72'({oBusy, oMemRead}), 72'(0));
        check("rstmid_memaddr", 72'(oMemAddr), 72'(0));
        check("rstmid_outputs", 72'({oValid, oData, oMisaligned, oAccessFault}), 72'(0));
        check("rstmid_state", 72'(oState), 72'(0));
        iRST_N    = 1'b1;
        iMemReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge iCLK);
            check($sformatf("late_ready_c%0d", c), 72'({oValid, oBusy}), 72'(0));
        end
        iMemReady = 1'b0;
        runLoad(32'h200, 3'b010, 32'h12345678, 0, {3'b100, 32'h12345678}, 1'b0);

        repeat (2) @(negedge iCLK);
        check("queue_drained", 72'(exp_q.size()), 72'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
